vga_pattern_gen: RTL and testbench

Pixel-generation stage that sits directly downstream of `vga_sync`. It consumes the sync block's `hsync`, `vsync`, `pixel_x`, `pixel_y` and `video_on`, and produces registered 12-bit RGB plus re-timed sync outputs for the VGA connector. It offers four test patterns, one of which is a box that moves once per frame and bounces off the screen edges. The pattern mode is selected by an input that is re-latched only at frame boundaries, so a mode change never tears a frame.

---
 rtl/vga_pkg.sv | 93 +++++++++
 rtl/box_mover.sv | 44 ++++
 rtl/vga_pattern_gen.sv | 110 +++++++++++
 tb/tb_vga_pattern_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area geometry, bouncing-box geometry,
// 12-bit colour constants, pattern mode encodings and small colour/box helpers.
// Used by vga_sync, vga_pattern_gen and box_mover.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned BOX      = 32;
  localparam int unsigned STEP     = 2;
  localparam int unsigned BAR_W    = H_ACTIVE / 8;

  // 11-bit views so the bounce arithmetic never wraps.
  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
  localparam logic [10:0] BOX_W  = 11'(BOX);
  localparam logic [10:0] STEP_W = 11'(STEP);

  typedef logic [11:0] rgb_t;

  localparam rgb_t WHITE   = 12'hFFF;
  localparam rgb_t YELLOW  = 12'hFF0;
  localparam rgb_t CYAN    = 12'h0FF;
  localparam rgb_t GREEN   = 12'h0F0;
  localparam rgb_t MAGENTA = 12'hF0F;
  localparam rgb_t RED     = 12'hF00;
  localparam rgb_t BLUE    = 12'h00F;
  localparam rgb_t BLACK   = 12'h000;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  // One axis of the box: position of the low edge and direction (1 = increasing).
  typedef struct packed {
    logic       dir;
    logic [9:0] pos;
  } axis_t;

  // Colour-bar lookup; columns at or beyond the last threshold stay in bar 7.
  function automatic rgb_t bar_colour(input logic [9:0] x);
    logic [2:0] idx;
    rgb_t       col;
    idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(i * BAR_W)) idx = 3'(i);
    end
    unique case (idx)
      3'd0:    col = WHITE;
      3'd1:    col = YELLOW;
      3'd2:    col = CYAN;
      3'd3:    col = GREEN;
      3'd4:    col = MAGENTA;
      3'd5:    col = RED;
      3'd6:    col = BLUE;
      default: col = BLACK;
    endcase
    return col;
  endfunction

  // Next position/direction of one axis; limit is the visible extent of that axis.
  function automatic axis_t axis_next(input axis_t cur, input logic [10:0] limit);
    axis_t       nxt;
    logic [10:0] pos11;
    logic [10:0] fwd;
    logic [10:0] back;
    logic [10:0] far_edge;
    nxt      = cur;
    pos11    = {1'b0, cur.pos};
    fwd      = pos11 + STEP_W;
    back     = pos11 - STEP_W;
    far_edge = limit - BOX_W;
    if (cur.dir) begin
      if (fwd + BOX_W >= limit) begin
        nxt.pos = far_edge[9:0];
        nxt.dir = 1'b0;
      end else begin
        nxt.pos = fwd[9:0];
      end
    end else begin
      if (pos11 <= STEP_W) begin
        nxt.pos = '0;
        nxt.dir = 1'b1;
      end else begin
        nxt.pos = back[9:0];
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/box_mover.sv
// Bouncing-box state. Holds the box position and direction for both axes and
// advances them by one step whenever en_i is high (once per frame).
//   clk_i     pixel clock
//   rst_ni    asynchronous active-low reset; box returns to (0,0) moving down-right
//   en_i      frame tick
//   box_x_o   left edge of the box
//   box_y_o   top edge of the box
module box_mover
  import vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [9:0] box_x_o,
  output logic [9:0] box_y_o
);

  axis_t x_q, x_d;
  axis_t y_q, y_d;

  // Both axes step on the same tick, so a corner hit flips both directions.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      x_d = axis_next(x_q, H_LIM);
      y_d = axis_next(y_q, V_LIM);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '{dir: 1'b1, pos: 10'd0};
      y_q <= '{dir: 1'b1, pos: 10'd0};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign box_x_o = x_q.pos;
  assign box_y_o = y_q.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel-generation stage downstream of vga_sync. Two-stage pipeline: stage 1
// registers the incoming pixel coordinates and sync bits, stage 2 computes the
// selected test pattern and registers it alongside the delayed syncs.
//   clk         pixel clock
//   rst         asynchronous active-low reset
//   hsync_in    horizontal sync from vga_sync (active-low)
//   vsync_in    vertical sync from vga_sync (active-low)
//   pixel_x/y   current column/row
//   video_on    high inside the visible area
//   mode        pattern select, latched only at the frame tick
//   rgb         registered {R,G,B} colour, 4 bits each
//   hsync/vsync syncs delayed by 2 clocks to stay aligned with rgb
//   frame_tick  one-clock pulse for the last visible pixel of a frame
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic [1:0]  mode,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam logic [9:0] XLast = 10'(H_ACTIVE - 1);
  localparam logic [9:0] YLast = 10'(V_ACTIVE - 1);

  // Stage 1
  logic [9:0] x_q, y_q;
  logic       von_q, hs1_q, vs1_q;
  // Stage 2
  rgb_t       rgb_q, rgb_d;
  logic       hs2_q, vs2_q, tick_q;
  mode_e      mode_q;

  logic       tick;
  logic [9:0] box_x, box_y;
  logic [10:0] x11, y11, bx11, by11;
  logic       in_box;
  logic [3:0] grey;

  assign tick = von_q && (x_q == XLast) && (y_q == YLast);

  box_mover u_box (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (tick),
    .box_x_o (box_x),
    .box_y_o (box_y)
  );

  always_comb begin
    x11    = {1'b0, x_q};
    y11    = {1'b0, y_q};
    bx11   = {1'b0, box_x};
    by11   = {1'b0, box_y};
    in_box = (bx11 <= x11) && (x11 < bx11 + BOX_W) &&
             (by11 <= y11) && (y11 < by11 + BOX_W);
    grey   = x_q[9:6];
    rgb_d  = BLACK;
    if (von_q) begin
      unique case (mode_q)
        MODE_BARS:  rgb_d = bar_colour(x_q);
        MODE_CHECK: rgb_d = (x_q[5] ^ y_q[5]) ? WHITE : BLACK;
        MODE_BOX:   rgb_d = in_box ? RED : BLUE;
        MODE_RAMP:  rgb_d = {grey, grey, grey};
        default:    rgb_d = BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      von_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      rgb_q  <= BLACK;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      tick_q <= 1'b0;
      mode_q <= MODE_BARS;
    end else begin
      x_q    <= pixel_x;
      y_q    <= pixel_y;
      von_q  <= video_on;
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      rgb_q  <= rgb_d;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      tick_q <= tick;
      // The last pixel of a frame still uses the old mode; the new one starts next.
      if (tick) mode_q <= mode_e'(mode);
    end
  end

  assign rgb        = rgb_q;
  assign hsync      = hs2_q;
  assign vsync      = vs2_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: a driver issues one pixel per clock and
// queues the colour/sync/tick the reference model expects two clocks later; a
// monitor pops and compares on every falling edge.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b1, vsync_in = 1'b1, video_on = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [1:0]  mode = '0;
  logic [11:0] rgb;
  logic        hsync, vsync, frame_tick;

  always #20 clk = ~clk;

  vga_pattern_gen dut (
    .clk        (clk),
    .rst        (rst),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .mode       (mode),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int unsigned due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        ft;
    int          x;
    int          y;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  // Reference state: frame ticks seen, latched mode, and a tick awaiting its effect.
  int          k_ticks = 0;
  logic [1:0]  mode_m = 2'd0;
  bit          pending = 1'b0;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

  always @(posedge clk) cyc <= cyc + 1;

  // Bouncing position as a triangle wave over tick count: 0, 2, ... lim-BOX, ... 2, 0.
  function automatic int tri_pos(input int k, input int lim);
    int half;
    int m;
    half = (lim - BOX) / STEP;
    m    = k % (2 * half);
    return (m <= half) ? STEP * m : STEP * (2 * half - m);
  endfunction

  function automatic logic [11:0] ref_colour(input int x, input int y, input logic [1:0] m,
                                             input int k);
    int         bx, by;
    logic [3:0] g;
    bx = tri_pos(k, H_ACTIVE);
    by = tri_pos(k, V_ACTIVE);
    g  = 4'(x / 64);
    case (m)
      2'd0:    return bars[x / 80];
      2'd1:    return (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2'd2:    return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 12'hF00 : 12'h00F;
      default: return {g, g, g};
    endcase
  endfunction

  task automatic drive(input int x, input int y, input bit von, input bit hs, input bit vs,
                       input logic [1:0] md);
    exp_t e;
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    mode     = md;
    // A tick latches the mode present on the clock after the tick pixel.
    if (pending) begin
      mode_m  = md;
      k_ticks = k_ticks + 1;
      pending = 1'b0;
    end
    e.due = cyc + 2;
    e.rgb = von ? ref_colour(x, y, mode_m, k_ticks) : 12'h000;
    e.hs  = hs;
    e.vs  = vs;
    e.ft  = von && (x == H_ACTIVE - 1) && (y == V_ACTIVE - 1);
    e.x   = x;
    e.y   = y;
    sb.push_back(e);
    if (e.ft) pending = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    n_chk++;
    if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b tick=%b, want rgb=000 hs=1 vs=1 tick=0",
               name, rgb, hsync, vsync, frame_tick);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL missed: pixel (%0d,%0d) due at cycle %0d never compared", e.x, e.y, e.due);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        n_chk++;
        if ({rgb, hsync, vsync, frame_tick} !== {e.rgb, e.hs, e.vs, e.ft}) begin
          n_fail++;
          $display("FAIL pixel (%0d,%0d): got rgb=%h hs=%b vs=%b tick=%b, want rgb=%h hs=%b vs=%b tick=%b",
                   e.x, e.y, rgb, hsync, vsync, frame_tick, e.rgb, e.hs, e.vs, e.ft);
        end
      end
    end
  end

  task automatic tick_and_probe(input logic [1:0] md);
    int bx, by;
    drive(H_ACTIVE - 1, V_ACTIVE - 1, 1, 1, 1, md);
    drive($urandom_range(H_ACTIVE - 1), $urandom_range(V_ACTIVE - 1), 1, 1, 1, md);
    bx = tri_pos(k_ticks, H_ACTIVE);
    by = tri_pos(k_ticks, V_ACTIVE);
    drive(bx, by, 1, 1, 1, md);
    drive(bx + BOX - 1, by + BOX - 1, 1, 1, 1, md);
    if (bx + BOX < H_ACTIVE) drive(bx + BOX, by, 1, 1, 1, md);
    if (by + BOX < V_ACTIVE) drive(bx, by + BOX, 1, 1, 1, md);
    if (bx > 0) drive(bx - 1, by, 1, 1, 1, md);
    if (by > 0) drive(bx, by - 1, 1, 1, 1, md);
  endtask

  task automatic release_reset();
    @(negedge clk);
    pixel_x  = '0;
    pixel_y  = '0;
    video_on = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rst      = 1'b1;
  endtask

  initial begin
    int  x, y;
    bit  von, hs, vs;
    logic [1:0] md;

    // Power-on reset
    #5 rst = 1'b0;
    #1 check_reset_outputs("por_reset");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por_reset_clocked");
    release_reset();

    // Colour bars across one line, plus pipeline warm-up
    for (int i = 0; i < H_ACTIVE; i++) drive(i, 0, 1, 1, 1, 2'd0);

    // Latch checkerboard and sample it
    drive(H_ACTIVE - 1, V_ACTIVE - 1, 1, 1, 1, 2'd1);
    drive(32, 0, 1, 1, 1, 2'd1);
    drive(0, 0, 1, 1, 1, 2'd1);
    drive(33, 40, 1, 1, 1, 2'd1);
    drive(100, 100, 0, 1, 1, 2'd1);

    // Requesting box mode mid-frame must not change the pattern yet
    for (int i = 0; i < 20; i++)
      drive($urandom_range(H_ACTIVE - 1), $urandom_range(V_ACTIVE - 2), 1, 1, 1, 2'd2);
    drive(H_ACTIVE - 1, V_ACTIVE - 1, 1, 1, 1, 2'd2);
    drive(0, 0, 1, 1, 1, 2'd2);

    // Many frames of box mode: covers the right/bottom bounce and the return to 0
    while (k_ticks < 620) tick_and_probe(2'd2);

    // hsync pulse of 96 clocks
    for (int i = 0; i < 96; i++)
      drive($urandom_range(H_ACTIVE - 1), $urandom_range(V_ACTIVE - 1), 1, 0, 1, 2'd2);
    for (int i = 0; i < 4; i++) drive(10, 10, 1, 1, 1, 2'd2);

    // Randomised mix of modes, blanking, syncs and ticks
    md = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) md = 2'($urandom_range(3));
      x   = $urandom_range(H_ACTIVE - 1);
      y   = $urandom_range(V_ACTIVE - 1);
      von = ($urandom_range(7) != 0);
      hs  = ($urandom_range(15) != 0);
      vs  = ($urandom_range(15) != 0);
      if ($urandom_range(24) == 0) begin
        x   = H_ACTIVE - 1;
        y   = V_ACTIVE - 1;
        von = 1'b1;
      end
      drive(x, y, von, hs, vs, md);
    end

    // Mid-line reset with non-idle outputs in flight
    drive(5, 7, 1, 0, 0, 2'd0);
    drive(6, 7, 1, 0, 0, 2'd0);
    @(posedge clk);
    #5 rst = 1'b0;
    #1 check_reset_outputs("midline_reset");
    sb.delete();
    k_ticks = 0;
    mode_m  = 2'd0;
    pending = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("midline_reset_held");
    release_reset();

    // Box restarts from (0,0): first tick puts it at (2,2)
    for (int i = 0; i < 4; i++) drive(i, 0, 1, 1, 1, 2'd0);
    tick_and_probe(2'd2);
    drive(1, 1, 1, 1, 1, 2'd2);
    drive(2, 2, 1, 1, 1, 2'd2);
    drive(34, 2, 1, 1, 1, 2'd2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) drive(0, 0, 0, 1, 1, 2'd2);
    repeat (4) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected outputs left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
